// File: rtl/rng_word_arbiter.sv
// Word queue plus round-robin arbiter between the bit packer and NUM_REQ consumers.
// The packer cannot be stalled, so packer_en throttles it and dropped words are counted.
module rng_word_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 4,
  parameter int WORD_W  = 16,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WORD_W-1:0]          in_word,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [WORD_W-1:0]          gnt_word,
  output logic                       packer_en,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic [CNT_W-1:0]           overflow_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]    THRESH_C  = CW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] OVF_MAX_C = '1;

  logic [WORD_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [WORD_W-1:0]  gnt_word_q, gnt_word_d;
  logic               packer_en_q, packer_en_d;
  logic [CNT_W-1:0]   ovf_q, ovf_d;

  logic               pop;
  logic               push_acc;
  logic               drop;
  logic               win_found;
  logic [PW-1:0]      win_idx;

  // Cyclic search for the first active request starting at rr_ptr.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  assign pop      = (count_q != '0) && win_found;
  assign push_acc = in_valid && ((count_q < DEPTH_C) || pop);
  assign drop     = in_valid && !push_acc;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = '0;
    gnt_word_d  = gnt_word_q;
    ovf_d       = ovf_q;
    count_d     = count_q;

    if (pop) begin
      grant_d    = NUM_REQ'(1) << win_idx;
      gnt_word_d = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + AW'(1);
      rr_ptr_d   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PW'(1);
    end

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (drop && (ovf_q != OVF_MAX_C)) begin
      ovf_d = ovf_q + CNT_W'(1);
    end

    if (push_acc && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_acc) begin
      count_d = count_q - CW'(1);
    end

    // One slot of slack for a word the packer may already have in flight.
    packer_en_d = (count_d < THRESH_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rr_ptr_q    <= '0;
      count_q     <= '0;
      grant_q     <= '0;
      gnt_word_q  <= '0;
      packer_en_q <= 1'b1;
      ovf_q       <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      grant_q     <= grant_d;
      gnt_word_q  <= gnt_word_d;
      packer_en_q <= packer_en_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_acc) begin
      mem_q[wr_ptr_q] <= in_word;
    end
  end

  assign grant        = grant_q;
  assign gnt_word     = gnt_word_q;
  assign packer_en    = packer_en_q;
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_rng_word_arbiter.sv
// Directed self-checking bench for rng_word_arbiter with hand-computed expectations.
module tb_rng_word_arbiter;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_word;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [15:0] gnt_word;
  logic        packer_en;
  logic [2:0]  count;
  logic        empty;
  logic        full;
  logic [7:0]  overflow_cnt;

  int n_checks;
  int n_fail;

  rng_word_arbiter #(.NUM_REQ(4), .DEPTH(4), .WORD_W(16), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_word      (in_word),
    .req          (req),
    .grant        (grant),
    .gnt_word     (gnt_word),
    .packer_en    (packer_en),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow_cnt (overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    in_valid = 1'b1;
    in_word  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b0;
  endtask

  logic [3:0]  exp_g [4];
  logic [15:0] exp_w [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_word  = '0;
    req      = '0;

    // Reset and idle
    do_reset(2);
    check("rst_gnt_word", 32'(gnt_word), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_grant", 32'(grant), 32'h0);
      check("idle_count", 32'(count), 32'h0);
      check("idle_empty", 32'(empty), 32'h1);
      check("idle_full", 32'(full), 32'h0);
      check("idle_packer_en", 32'(packer_en), 32'h1);
      check("idle_ovf", 32'(overflow_cnt), 32'h0);
    end

    // Single push then grant
    push(16'hA5C3);
    check("single_count_after_push", 32'(count), 32'h1);
    check("single_grant_before_req", 32'(grant), 32'h0);
    req = 4'b0100;
    tick();
    check("single_grant", 32'(grant), 32'h4);
    check("single_word", 32'(gnt_word), 32'hA5C3);
    check("single_count_after_pop", 32'(count), 32'h0);
    req = 4'b0000;
    tick();
    check("single_grant_drop", 32'(grant), 32'h0);
    check("single_word_hold", 32'(gnt_word), 32'hA5C3);

    // Round-robin fairness, starting from a fresh rr pointer
    do_reset(1);
    for (int i = 0; i < 4; i++) push(16'(i + 1));
    check("rr_full_preload", 32'(full), 32'h1);
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000;
    exp_w[0] = 16'h0001; exp_w[1] = 16'h0002; exp_w[2] = 16'h0003; exp_w[3] = 16'h0004;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr_grant%0d", i), 32'(grant), 32'(exp_g[i]));
      check($sformatf("rr_word%0d", i), 32'(gnt_word), 32'(exp_w[i]));
    end
    req = 4'b0000;
    check("rr_empty", 32'(empty), 32'h1);
    tick();
    check("rr_idle_grant", 32'(grant), 32'h0);
    // rr pointer wrapped to 0: consumer 0 wins next
    push(16'h0055);
    req = 4'b1111;
    tick();
    check("rr_wrap_grant", 32'(grant), 32'h1);
    check("rr_wrap_word", 32'(gnt_word), 32'h0055);
    req = 4'b0000;
    tick();

    // Overflow and pointer wrap
    push(16'h1000);
    check("ovf_pen1", 32'(packer_en), 32'h1);
    push(16'h1001);
    check("ovf_pen2", 32'(packer_en), 32'h1);
    push(16'h1002);
    check("ovf_pen3", 32'(packer_en), 32'h0);
    check("ovf_full3", 32'(full), 32'h0);
    push(16'h1003);
    check("ovf_full4", 32'(full), 32'h1);
    check("ovf_cnt4", 32'(overflow_cnt), 32'h0);
    push(16'h1004);
    check("ovf_cnt5", 32'(overflow_cnt), 32'h1);
    push(16'h1005);
    check("ovf_cnt6", 32'(overflow_cnt), 32'h2);
    check("ovf_count6", 32'(count), 32'h4);
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("ovf_grant%0d", i), 32'(grant), 32'h1);
      check($sformatf("ovf_word%0d", i), 32'(gnt_word), 32'(16'h1000 + i));
    end
    req = 4'b0000;
    check("ovf_drained_empty", 32'(empty), 32'h1);
    check("ovf_drained_pen", 32'(packer_en), 32'h1);
    tick();
    check("ovf_drained_grant", 32'(grant), 32'h0);

    // Simultaneous push and pop at full
    for (int i = 0; i < 4; i++) push(16'(16'h2000 + i));
    check("pp_full", 32'(full), 32'h1);
    in_valid = 1'b1;
    in_word  = 16'hBEEF;
    req      = 4'b0010;
    tick();
    in_valid = 1'b0;
    check("pp_grant", 32'(grant), 32'h2);
    check("pp_word", 32'(gnt_word), 32'h2000);
    check("pp_count", 32'(count), 32'h4);
    check("pp_ovf", 32'(overflow_cnt), 32'h2);
    req = 4'b0001;
    exp_w[0] = 16'h2001; exp_w[1] = 16'h2002; exp_w[2] = 16'h2003; exp_w[3] = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("pp_grant%0d", i), 32'(grant), 32'h1);
      check($sformatf("pp_word%0d", i), 32'(gnt_word), 32'(exp_w[i]));
    end
    req = 4'b0000;
    tick();

    // Reset mid-operation
    for (int i = 0; i < 3; i++) push(16'(16'h3000 + i));
    check("mid_count3", 32'(count), 32'h3);
    req   = 4'b1111;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_grant", 32'(grant), 32'h0);
    check("mid_count", 32'(count), 32'h0);
    check("mid_gnt_word", 32'(gnt_word), 32'h0);
    check("mid_pen", 32'(packer_en), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_stale%0d", i), 32'(grant), 32'h0);
    end
    in_valid = 1'b1;
    in_word  = 16'h7777;
    tick();
    in_valid = 1'b0;
    check("mid_no_bypass", 32'(grant), 32'h0);
    tick();
    check("mid_new_grant", 32'(grant), 32'h1);
    check("mid_new_word", 32'(gnt_word), 32'h7777);
    req = 4'b0000;
    tick();
    check("mid_final_empty", 32'(empty), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (!reset && !$isunknown(grant) && !$onehot0(grant)) begin
      $error("FAIL grant_onehot: got %b, expected at most one bit set", grant);
    end
  end

endmodule
